// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg
// Shared constants and helpers for the stereo serial-audio receiver.
//   MODE_I2S / MODE_LJ : values of the 'mode' pin (bit-delay selection)
//   clog2()            : width helper for counters and FIFO pointers
package i2s_rx_pkg;

    localparam logic MODE_I2S = 1'b0;  // MSB arrives one sck after the ws edge
    localparam logic MODE_LJ  = 1'b1;  // MSB arrives on the ws edge itself

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_rx_stereo_if.sv
// i2s_rx_stereo_if
// Frame output stream of the receiver.
//   m_data  : {left, right} frame word
//   m_valid : a frame is available
//   m_ready : consumer accepts
// Handshake: a transfer happens on every sck posedge where m_valid && m_ready
// are both high. m_valid never waits for m_ready, and m_data stays stable
// while m_valid is high and no transfer has happened. m_ready while m_valid
// is low has no effect.
interface i2s_rx_stereo_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo
// Small synchronous frame FIFO. Read data comes straight out of the storage
// registers (show-ahead), so pop_data is the head entry whenever !empty.
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write request; accepted when not full, or when full
//                        together with a pop
//   pop                : read request; ignored when empty
//   full, empty        : occupancy flags
//   pop_data           : head entry (zero after reset)
module i2s_rx_fifo
    import i2s_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/i2s_rx_stereo.sv
// i2s_rx_stereo
// Stereo I2S / left-justified receiver. Each ws slot is deserialised MSB
// first, truncated or zero-filled to DATA_WIDTH, and every left+right pair
// is pushed as one frame word into a small FIFO.
//   sck        : bit clock, only clock (posedge)
//   rst_n      : asynchronous active-low reset
//   mode       : 0 = Philips I2S (one-bit delay), 1 = left-justified
//   ws, sda    : word select (0 = left) and serial data
//   clr        : clears the sticky overflow flag
//   m_if       : frame stream {left, right} with valid/ready
//   overflow   : sticky, a frame was dropped on a full FIFO
//   short_slot : one-cycle pulse, the completed slot had < DATA_WIDTH bits
module i2s_rx_stereo
    import i2s_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               sck,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               ws,
    input  logic               sda,
    input  logic               clr,
    i2s_rx_stereo_if.master    m_if,
    output logic               overflow,
    output logic               short_slot
);

    localparam int PW = clog2(DATA_WIDTH + 2);
    localparam int CW = clog2(DATA_WIDTH + 1);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_DW   = PW'(DATA_WIDTH);
    localparam logic [PW-1:0] POS_MAX  = PW'(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    // Input stage and open-slot state
    logic                  ws_q, ws_d;
    logic                  armed_q, armed_d;
    logic                  open_q, open_d;     // slot was opened by an observed edge
    logic                  ch_q, ch_d;         // channel of the open slot
    logic                  mode_q, mode_d;     // mode latched at the opening edge
    logic [PW-1:0]         pos_q, pos_d;       // sck cycles since opening edge
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;       // bits captured so far

    // Closed slot waiting for completion on the next posedge
    logic                  done_v_q, done_v_d;
    logic                  done_ch_q, done_ch_d;
    logic [DATA_WIDTH-1:0] done_data_q, done_data_d;
    logic                  done_short_q, done_short_d;

    // Frame assembly and flags
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_ok_q, left_ok_d;
    logic                  short_q, short_d;
    logic                  overflow_q, overflow_d;

    logic                  edge_e;
    logic                  cap_cur;
    logic [DATA_WIDTH-1:0] shift_cur;
    logic [CW-1:0]         cnt_cur;
    logic [DATA_WIDTH-1:0] fin_shift;
    logic [CW-1:0]         fin_cnt;
    logic                  push_req;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*DATA_WIDTH-1:0] fifo_dout;

    assign edge_e = armed_q && (ws != ws_q);

    // Does this sample carry bit index 0..DATA_WIDTH-1 of the open slot?
    // I2S shifts indices one position later than left-justified.
    assign cap_cur   = (mode_q == MODE_I2S) ? ((pos_q >= POS_ONE) && (pos_q <= POS_DW))
                                            : (pos_q < POS_DW);
    assign shift_cur = {shift_q[DATA_WIDTH-2:0], sda};
    assign cnt_cur   = cnt_q + 1'b1;

    always_comb begin
        ws_d         = ws;
        armed_d      = 1'b1;
        open_d       = open_q;
        ch_d         = ch_q;
        mode_d       = mode_q;
        pos_d        = pos_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        done_v_d     = 1'b0;
        done_ch_d    = done_ch_q;
        done_data_d  = done_data_q;
        done_short_d = done_short_q;
        fin_shift    = shift_q;
        fin_cnt      = cnt_q;

        if (edge_e) begin
            // In I2S mode the edge sample is still the LSB of the closing slot;
            // in left-justified mode it already belongs to the new slot.
            if ((mode_q == MODE_I2S) && cap_cur) begin
                fin_shift = shift_cur;
                fin_cnt   = cnt_cur;
            end
            done_v_d     = open_q;
            done_ch_d    = ch_q;
            done_data_d  = fin_shift << (CNT_FULL - fin_cnt);  // zero-fill missing LSBs
            done_short_d = (fin_cnt < CNT_FULL);

            open_d = 1'b1;
            ch_d   = ws;
            mode_d = mode;
            pos_d  = POS_ONE;
            if (mode == MODE_LJ) begin
                shift_d = {{(DATA_WIDTH-1){1'b0}}, sda};
                cnt_d   = CW'(1);
            end else begin
                shift_d = '0;
                cnt_d   = '0;
            end
        end else begin
            if (cap_cur) begin
                shift_d = shift_cur;
                cnt_d   = cnt_cur;
            end
            if (pos_q != POS_MAX) begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // Slot completion: left slots park in the holding register, a right slot
    // only forms a frame when a left slot precedes it.
    always_comb begin
        short_d     = done_v_q && done_short_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        push_req    = 1'b0;
        if (done_v_q) begin
            if (done_ch_q == 1'b0) begin
                left_hold_d = done_data_q;
                left_ok_d   = 1'b1;
            end else begin
                push_req  = left_ok_q;
                left_ok_d = 1'b0;
            end
        end
        overflow_d = (overflow_q && !clr) || (push_req && fifo_full && !pop);
    end

    assign pop = !fifo_empty && m_if.m_ready;

    i2s_rx_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sck),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data ({left_hold_q, done_data_q}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .pop_data  (fifo_dout)
    );

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            ws_q         <= 1'b0;
            armed_q      <= 1'b0;
            open_q       <= 1'b0;
            ch_q         <= 1'b0;
            mode_q       <= MODE_I2S;
            pos_q        <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            done_v_q     <= 1'b0;
            done_ch_q    <= 1'b0;
            done_data_q  <= '0;
            done_short_q <= 1'b0;
            left_hold_q  <= '0;
            left_ok_q    <= 1'b0;
            short_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ws_q         <= ws_d;
            armed_q      <= armed_d;
            open_q       <= open_d;
            ch_q         <= ch_d;
            mode_q       <= mode_d;
            pos_q        <= pos_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            done_v_q     <= done_v_d;
            done_ch_q    <= done_ch_d;
            done_data_q  <= done_data_d;
            done_short_q <= done_short_d;
            left_hold_q  <= left_hold_d;
            left_ok_q    <= left_ok_d;
            short_q      <= short_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_if.m_data  = fifo_dout;
    assign m_if.m_valid = !fifo_empty;
    assign overflow     = overflow_q;
    assign short_slot   = short_q;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// tb_i2s_rx_stereo
// Directed bench: a table of single-frame vectors plus hand-written
// sequences for mode switching, overflow, ws high at reset and reset
// in the middle of a frame. Inputs change and outputs are sampled on the
// sck negedge.
module tb_i2s_rx_stereo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic sck   = 1'b0;
    logic rst_n = 1'b0;
    logic mode  = 1'b0;
    logic ws    = 1'b0;
    logic sda   = 1'b0;
    logic clr   = 1'b0;
    logic overflow;
    logic short_slot;

    i2s_rx_stereo_if #(.DATA_WIDTH(DW)) m_if ();

    i2s_rx_stereo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sck        (sck),
        .rst_n      (rst_n),
        .mode       (mode),
        .ws         (ws),
        .sda        (sda),
        .clr        (clr),
        .m_if       (m_if),
        .overflow   (overflow),
        .short_slot (short_slot)
    );

    // Clock
    always #5 sck = ~sck;

    int   vec_cnt   = 0;
    int   err_cnt   = 0;
    int   short_cnt = 0;
    int   short_base = 0;
    logic pending_lsb = 1'b0;
    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        logic        m;
        int          n;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp_data;
        int          exp_short;
    } vec_t;

    vec_t tbl[10];

    always @(negedge sck) begin
        if (short_slot === 1'b1) short_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic w);
        rst_n       = 1'b0;
        ws          = w;
        sda         = 1'b0;
        clr         = 1'b0;
        mode        = 1'b0;
        m_if.m_ready = 1'b0;
        pending_lsb = 1'b0;
        repeat (2) @(negedge sck);
        rst_n      = 1'b1;
        short_base = short_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sck);
            sda = 1'b0;
        end
    endtask

    // One slot of n sck cycles on channel w. In I2S style the first cycle
    // carries the previous slot's LSB and this slot's LSB goes out on the
    // next edge cycle.
    task automatic send_slot(input logic w, input logic [31:0] val, input int n,
                             input logic m, input int chg_at, input logic chg_mode);
        for (int p = 0; p < n; p++) begin
            @(negedge sck);
            if (p == 0) mode = m;
            else if (p == chg_at) mode = chg_mode;
            ws = w;
            if (m) sda = val[n-1-p];
            else   sda = (p == 0) ? pending_lsb : val[n-p];
        end
        pending_lsb = val[0];
    endtask

    task automatic send_frame(input logic m, input int n, input logic [31:0] l, input logic [31:0] r);
        send_slot(1'b0, l, n, m, -1, 1'b0);
        send_slot(1'b1, r, n, m, -1, 1'b0);
    endtask

    // Closing edge, then latency, data, pop and short-pulse checks.
    task automatic check_frame(input string tag, input logic [31:0] exp_data, input int exp_short);
        @(negedge sck);
        ws  = 1'b0;
        sda = pending_lsb;
        idle(1);
        chk($sformatf("%s valid_after_E", tag), m_if.m_valid, 1'b0);
        idle(1);
        chk($sformatf("%s valid_after_E1", tag), m_if.m_valid, 1'b1);
        chk($sformatf("%s data", tag), m_if.m_data, exp_data);
        m_if.m_ready = 1'b1;
        idle(1);
        m_if.m_ready = 1'b0;
        chk($sformatf("%s valid_after_pop", tag), m_if.m_valid, 1'b0);
        chk($sformatf("%s short_pulses", tag), short_cnt - short_base, exp_short);
    endtask

    initial begin
        tbl[0] = '{1'b0, 32, {16'hA5A5, 16'($urandom)}, {16'h5A5A, 16'($urandom)}, 32'hA5A55A5A, 0};
        tbl[1] = '{1'b1, 32, {16'hA5A5, 16'($urandom)}, {16'h5A5A, 16'($urandom)}, 32'hA5A55A5A, 0};
        tbl[2] = '{1'b1,  8, 32'h000000C3, 32'h00000081, 32'hC3008100, 2};
        tbl[3] = '{1'b0, 16, 32'h00001357, 32'h00009BDF, 32'h13579BDF, 0};
        tbl[4] = '{1'b1, 16, 32'h0000FFFF, 32'h00000001, 32'hFFFF0001, 0};
        tbl[5] = '{1'b0, 17, 32'h00017DDF, 32'h00001E1E, 32'hBEEF0F0F, 0};
        tbl[6] = '{1'b0,  8, 32'h0000007E, 32'h00000001, 32'h7E000100, 2};
        tbl[7] = '{1'b0,  2, 32'h00000003, 32'h00000001, 32'hC0004000, 2};
        tbl[8] = '{1'b1,  1, 32'h00000001, 32'h00000000, 32'h80000000, 2};
        tbl[9] = '{1'b1, 24, 32'h00123456, 32'h00ABCDEF, 32'h1234ABCD, 0};

        // Reset state
        do_reset(1'b0);
        chk("reset m_valid", m_if.m_valid, 1'b0);
        chk("reset m_data", m_if.m_data, '0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset short_slot", short_slot, 1'b0);

        // Table of single frames; ws high before the first left edge so the
        // unobserved first slot is dropped.
        for (int i = 0; i < 10; i++) begin
            do_reset(1'b1);
            idle(3);
            send_frame(tbl[i].m, tbl[i].n, tbl[i].l, tbl[i].r);
            check_frame($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_short);
        end

        // Mode pin changes mid left slot: left stays left-justified, right uses I2S
        do_reset(1'b1);
        idle(3);
        send_slot(1'b0, 32'h0000_0F1E, 16, 1'b1, 5, 1'b0);
        send_slot(1'b1, 32'h0000_2D3C, 16, 1'b0, -1, 1'b0);
        check_frame("mode_switch", 32'h0F1E2D3C, 0);

        // Overflow: five frames into a four-deep FIFO with no consumer
        do_reset(1'b1);
        idle(3);
        for (int k = 0; k < 5; k++) begin
            logic [15:0] l16;
            logic [15:0] r16;
            l16 = 16'h1100 + 16'(k);
            r16 = 16'h2200 + 16'(k);
            send_frame(1'b0, 16, {16'h0, l16}, {16'h0, r16});
            if (k < DEPTH) exp_q.push_back({l16, r16});
        end
        @(negedge sck);
        ws  = 1'b0;
        sda = pending_lsb;
        idle(3);
        chk("ovf overflow_set", overflow, 1'b1);
        chk("ovf m_valid", m_if.m_valid, 1'b1);
        @(negedge sck);
        clr = 1'b1;
        @(negedge sck);
        clr = 1'b0;
        chk("ovf overflow_cleared", overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            logic [2*DW-1:0] e;
            e = exp_q.pop_front();
            chk($sformatf("drain%0d valid", i), m_if.m_valid, 1'b1);
            chk($sformatf("drain%0d data", i), m_if.m_data, e);
            m_if.m_ready = 1'b1;
            @(negedge sck);
            m_if.m_ready = 1'b0;
        end
        chk("drain empty", m_if.m_valid, 1'b0);

        // ws high through reset release, short unopened right slot first
        do_reset(1'b1);
        idle(5);
        send_frame(1'b0, 16, 32'h0000_1111, 32'h0000_2222);
        check_frame("ws_high_at_reset", 32'h11112222, 0);

        // Reset in the middle of a right slot with a frame already buffered
        do_reset(1'b1);
        idle(3);
        send_frame(1'b0, 16, 32'h0000_DEAD, 32'h0000_BEEF);
        send_slot(1'b0, 32'h0000_5555, 16, 1'b0, -1, 1'b0);
        send_slot(1'b1, 32'h0000_00A7, 8, 1'b0, -1, 1'b0);
        chk("midrst valid_before", m_if.m_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst valid_in_reset", m_if.m_valid, 1'b0);
        chk("midrst data_in_reset", m_if.m_data, '0);
        @(negedge sck);
        @(negedge sck);
        rst_n       = 1'b1;
        short_base  = short_cnt;
        pending_lsb = 1'b0;
        idle(8);
        send_frame(1'b0, 16, 32'h0000_1234, 32'h0000_ABCD);
        check_frame("after_reset", 32'h1234ABCD, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
Name: i2s_rx_stereo

Overview:
Parametrised stereo I2S/left-justified serial-audio receiver. Deserialises left (ws=0) and right (ws=1) slots of any length on `sda` and truncates or zero-pads each to DATA_WIDTH. Packs each left+right pair into one frame word and buffers it in a small FIFO with a valid/ready output. Sits between the codec pins and the audio packetiser in the Ethernet data-in path, all in the `sck` domain.

Parameters:
DATA_WIDTH, 16, sample width per channel (>=2); slot bits beyond this are discarded, missing bits are zero-filled.
FIFO_DEPTH, 4, frame buffer depth in stereo frames (power of 2, >=2).

Ports:
sck  input  1  serial bit clock; the only clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = Philips I2S (MSB one sck after ws edge), 1 = left-justified (MSB on ws edge).
ws  input  1  word select: 0 = left slot, 1 = right slot.
sda  input  1  serial data, MSB first.
clr  input  1  clears sticky flags.
m_data  output  2*DATA_WIDTH  frame word {left[DATA_WIDTH-1:0], right[DATA_WIDTH-1:0]}.
m_valid  output  1  FIFO non-empty.
m_ready  input  1  consumer accepts m_data when m_valid&&m_ready.
overflow  output  1  sticky; a frame was dropped because the FIFO was full.
short_slot  output  1  one-cycle pulse; the closing slot delivered fewer than DATA_WIDTH bits.

Behaviour:
- Reset: m_valid=0, m_data=0, overflow=0, short_slot=0; FIFO emptied; ws_q=0; armed=0; left_ok=0; shift registers=0.
- Input stage: ws_q<=ws and sda sampled every posedge. armed sets on the first posedge after reset release. Edge cycle E = armed && (ws != ws_q). No edge is detected before armed is set, so a ws=1 level at reset release is not treated as an edge.
- A slot opens at E and runs to the next E. The first slot after reset is discarded because it was not opened by an observed edge.
- mode is latched at each E and held for the whole new slot. Changing mode mid-slot has no effect until the next edge.
- Bit position p counts sck cycles since the opening E (p=0 at E). The counter saturates at DATA_WIDTH+1, so no wrap for long slots.
- Captured bit index = p - d, where d=1 for mode 0 and d=0 for mode 1. Bits with index 0..DATA_WIDTH-1 shift MSB-first into the channel register; others are ignored.
- Closing edge, mode 0: the sda sample taken at the closing E is the final (LSB) bit of the closing slot. It is shifted in only if index < DATA_WIDTH.
- Closing edge, mode 1: the sample at the closing E is the MSB of the new slot.
- Slot completion happens at posedge E+1.
  - If captured bits < DATA_WIDTH, the remaining LSBs are zero-filled and short_slot pulses high for exactly that cycle.
  - A completed left slot is stored in the left holding register and sets left_ok.
  - A completed right slot with left_ok=1 pushes {left,right} to the FIFO and clears left_ok.
  - A completed right slot with left_ok=0 is discarded. This keeps frame alignment left-then-right.
- FIFO: m_data = mem[rd_ptr] and m_valid = (count != 0), both driven from registers.
  - A push at posedge k gives m_valid=1 after k if the FIFO was empty. Latency is closing E -> m_valid = 2 posedges.
  - A pop occurs when m_valid && m_ready. m_ready with m_valid=0 is ignored.
- Full: a push with no simultaneous pop drops the new frame, FIFO contents are unchanged, and overflow is set.
- Full with simultaneous push and pop: both occur and the count stays at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.
- overflow stays set until clr=1 at a posedge. If clr and a new overflow event coincide, overflow stays 1 (set wins).
- Back-to-back edges (a 1-cycle slot) are legal: the slot completes as a short slot and is zero-filled.
- Asynchronous reset mid-slot or mid-frame: everything returns to reset values immediately. The partial frame is lost and reception resynchronises on the first edge after armed is set.

Decomposition:
- Package i2s_rx_pkg: constants MODE_I2S=1'b0 and MODE_LJ=1'b1, plus the clog2 helper function for counter and pointer widths.
- One sub-module, i2s_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/data.
- Serial capture, slot framing and flags stay in the top level.

Test Plan:
1. Mode 0, DATA_WIDTH=16, 32-bit slots, left=0xA5A5 then right=0x5A5A (LSBs beyond 16 random) -> one frame m_data=0xA5A55A5A, m_valid 2 cycles after closing edge, short_slot never pulses.
2. Mode 1, same data with no bit delay -> same m_data. Then switch mode to 0 mid-slot -> that slot still decoded as mode 1, the next slot decoded as mode 0.
3. 8-bit slots, left=0xC3, right=0x81 (mode 1) -> m_data=0xC3008100, short_slot pulses once per slot.
4. m_ready=0, send 5 frames with FIFO_DEPTH=4 -> 4 frames held in order, 5th dropped, overflow=1. Pulse clr -> overflow=0. Drain -> frames 1..4 in order.
5. Hold ws=1 through reset release, then start with a right slot -> no spurious edge, the lone right slot is discarded, and the first valid frame is the following left+right pair.
6. Assert rst_n=0 mid right slot, release, then send a full frame 0x1234/0xABCD -> m_valid=0 during reset, the post-reset first slot is discarded, and the next complete frame yields 0x1234ABCD.
